// File: rtl/buf_sched_pkg.sv
// rtl/buf_sched_pkg.sv - shared FSM encoding and default widths for the buffer scheduler
package buf_sched_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/buf_sched_rr_arb2.sv
// rtl/buf_sched_rr_arb2.sv - two-way round-robin write arbiter with combinational grant
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       able,
   output logic [1:0] gnt
);

   // pri names the requester favoured when both ask; it flips to the loser on each grant
   logic pri;

   always_comb begin
      gnt = 2'b00;
      if (able) begin
         if (req == 2'b11) gnt = pri ? 2'b10 : 2'b01;
         else              gnt = req;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            pri <= 1'b0;
      else if (gnt != 2'b00) pri <= gnt[0];
   end

endmodule

// File: rtl/buf_sched.sv
// rtl/buf_sched.sv - pass scheduler issuing buffer write/read strobes for a configured beat count
module buf_sched
   import buf_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int N_REQ = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_writes,
   input  logic [CNT_W-1:0] cfg_reads,
   input  logic [N_REQ-1:0] req,
   input  logic             able_write,
   input  logic             able_read,
   input  logic             cons_ready,
   output logic             rst_buf,
   output logic             write_en,
   output logic [N_REQ-1:0] gnt,
   output logic             read_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] rd_cnt
);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cfg_w, cfg_r;
   logic [CNT_W-1:0] wr_nx, rd_nx;
   logic             in_run, wr_able, start_ok;

   assign in_run   = (state == ST_RUN);
   assign start_ok = (state == ST_IDLE) && start && !abort;

   // abort gates the strobes so nothing is issued in the abort cycle
   assign wr_able  = in_run && !abort && able_write && (wr_cnt < cfg_w);
   assign read_en  = in_run && !abort && able_read && cons_ready && (rd_cnt < cfg_r);

   rr_arb2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .able (wr_able),
      .gnt  (gnt)
   );

   assign write_en = |gnt;
   assign wr_nx    = wr_cnt + CNT_W'(write_en);
   assign rd_nx    = rd_cnt + CNT_W'(read_en);

   assign rst_buf  = (state == ST_CLEAR);
   assign busy     = (state == ST_CLEAR) || in_run;
   assign done     = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // completion looks at the counts including this cycle's beats so done follows the last beat directly
   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state_nx = ST_CLEAR;
            ST_CLEAR: state_nx = ST_RUN;
            ST_RUN:   if ((wr_nx == cfg_w) && (rd_nx == cfg_r)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_w  <= '0;
         cfg_r  <= '0;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else if (start_ok) begin
         cfg_w  <= cfg_writes;
         cfg_r  <= cfg_reads;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         wr_cnt <= wr_nx;
         rd_cnt <= rd_nx;
      end
   end

endmodule

// File: tb/tb_buf_sched.sv
// tb/tb_buf_sched.sv - randomized scoreboard bench for buf_sched
module tb_buf_sched;

   localparam int P_IDLE  = 0;
   localparam int P_CLEAR = 1;
   localparam int P_RUN   = 2;
   localparam int P_DONE  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, abort = 1'b0;
   logic [7:0] cfg_writes = 8'd0, cfg_reads = 8'd0;
   logic [1:0] req = 2'b00;
   logic       able_write = 1'b0, able_read = 1'b0, cons_ready = 1'b0;
   logic       rst_buf, write_en, read_en, busy, done;
   logic [1:0] gnt;
   logic [7:0] wr_cnt, rd_cnt;

   buf_sched dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .cfg_writes (cfg_writes),
      .cfg_reads  (cfg_reads),
      .req        (req),
      .able_write (able_write),
      .able_read  (able_read),
      .cons_ready (cons_ready),
      .rst_buf    (rst_buf),
      .write_en   (write_en),
      .gnt        (gnt),
      .read_en    (read_en),
      .busy       (busy),
      .done       (done),
      .wr_cnt     (wr_cnt),
      .rd_cnt     (rd_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy;
      logic       rst_buf;
      logic       done;
      logic       write_en;
      logic       read_en;
      logic [1:0] gnt;
      logic [7:0] wr_cnt;
      logic [7:0] rd_cnt;
   } obs_t;

   obs_t       sq[$];
   logic [1:0] glog[$];
   int         cmp_n = 0;
   int         err_n = 0;
   bit         started = 1'b0;

   // reference model: pass phase, beats issued, latched cfg, favoured requester
   int ph = P_IDLE, mw = 0, mr = 0, cfw = 0, cfr = 0, pref = 0;

   function automatic obs_t dut_obs();
      obs_t o;
      o.busy = busy; o.rst_buf = rst_buf; o.done = done;
      o.write_en = write_en; o.read_en = read_en; o.gnt = gnt;
      o.wr_cnt = wr_cnt; o.rd_cnt = rd_cnt;
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && started) begin
         if (sq.size() == 0) begin
            cmp_n++;
            err_n++;
            $display("FAIL scoreboard_underrun at %0t", $time);
         end else begin
            obs_t e;
            e = sq.pop_front();
            check("cycle_outputs", 32'(dut_obs()), 32'(e));
            if (write_en) glog.push_back(gnt);
         end
      end
   end

   task automatic model_reset();
      ph = P_IDLE; mw = 0; mr = 0; cfw = 0; cfr = 0; pref = 0;
   endtask

   task automatic apply(input bit st, input bit ab, input int cw, input int cr,
                        input bit [1:0] rq, input bit aw, input bit ar, input bit rdy);
      obs_t e;
      bit   wr, rd;
      int   g;
      start = st; abort = ab; cfg_writes = 8'(cw); cfg_reads = 8'(cr);
      req = rq; able_write = aw; able_read = ar; cons_ready = rdy;
      e = '0;
      e.busy    = (ph == P_CLEAR) || (ph == P_RUN);
      e.rst_buf = (ph == P_CLEAR);
      e.done    = (ph == P_DONE);
      e.wr_cnt  = 8'(mw);
      e.rd_cnt  = 8'(mr);
      wr = (ph == P_RUN) && !ab && aw && (mw < cfw) && (rq != 2'b00);
      rd = (ph == P_RUN) && !ab && ar && rdy && (mr < cfr);
      g = 0;
      if (wr) begin
         if (rq == 2'b11) g = pref;
         else             g = (rq == 2'b01) ? 0 : 1;
         e.gnt = (g == 0) ? 2'b01 : 2'b10;
         e.write_en = 1'b1;
         pref = 1 - g;
      end
      e.read_en = rd;
      sq.push_back(e);
      if (ab) ph = P_IDLE;
      else begin
         case (ph)
            P_IDLE:  if (st) begin ph = P_CLEAR; cfw = cw; cfr = cr; mw = 0; mr = 0; end
            P_CLEAR: ph = P_RUN;
            P_RUN: begin
               mw += int'(wr);
               mr += int'(rd);
               if (mw == cfw && mr == cfr) ph = P_DONE;
            end
            default: ph = P_IDLE;
         endcase
      end
   endtask

   task automatic cyc_mode(input bit st, input bit ab, input int cw, input int cr,
                           input int mode, input int k);
      bit [1:0] rq;
      bit       aw, ar, rdy, s, a;
      int       w, r;
      s = st; a = ab; w = cw; r = cr;
      rq = 2'b01; aw = 1'b1; ar = 1'b1; rdy = 1'b1;
      case (mode)
         1: rq = 2'b11;
         2: aw = (k % 2 == 0);
         3: begin
            rq  = 2'($urandom_range(0, 3));
            aw  = ($urandom_range(0, 3) != 0);
            ar  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            a   = a || ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) begin
               s = 1'b1; w = $urandom_range(0, 7); r = $urandom_range(0, 7);
            end
         end
         default: ;
      endcase
      @(posedge clk);
      #1;
      apply(s, a, w, r, rq, aw, ar, rdy);
   endtask

   task automatic drive_pass(input string name, input int cw, input int cr, input int mode);
      int k;
      k = 0;
      cyc_mode(1'b1, 1'b0, cw, cr, mode, k);
      while (ph != P_IDLE && k < 200) begin
         k++;
         cyc_mode(1'b0, 1'b0, cw, cr, mode, k);
      end
      cmp_n++;
      if (ph != P_IDLE) begin
         err_n++;
         $display("FAIL %s pass_timeout actual_cycles=%0d required<200", name, k);
      end
      repeat (2) cyc_mode(1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   initial begin
      int k;
      #2;
      check("in_reset_outputs", 32'(dut_obs()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      started = 1'b1;
      apply(1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
      repeat (2) cyc_mode(1'b0, 1'b0, 0, 0, 0, 0);

      // both requesters held from a fresh pointer: alternate starting with requester 0
      glog.delete();
      drive_pass("rr6", 6, 0, 1);
      check("rr6_grant_count", 32'(glog.size()), 32'd6);
      for (int i = 0; i < 6 && i < glog.size(); i++)
         check("rr6_grant_seq", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

      glog.delete();
      drive_pass("basic44", 4, 4, 0);
      check("basic44_grant_count", 32'(glog.size()), 32'd4);
      for (int i = 0; i < glog.size(); i++) check("basic44_gnt", 32'(glog[i]), 32'd1);

      glog.delete();
      drive_pass("toggle2", 2, 0, 2);
      check("toggle2_write_count", 32'(glog.size()), 32'd2);

      drive_pass("zero_cfg", 0, 0, 0);
      drive_pass("reads_only", 0, 3, 0);

      // abort after two of five writes
      cyc_mode(1'b1, 1'b0, 5, 0, 0, 0);
      k = 0;
      while (ph != P_IDLE && k < 50) begin
         k++;
         cyc_mode(1'b0, (ph == P_RUN && mw == 2), 5, 0, 0, k);
      end
      check("abort_wr_cnt_model", 32'(mw), 32'd2);
      repeat (3) cyc_mode(1'b0, 1'b0, 0, 0, 0, 0);

      // start while running is ignored
      cyc_mode(1'b1, 1'b0, 3, 2, 0, 0);
      cyc_mode(1'b0, 1'b0, 3, 2, 0, 1);
      cyc_mode(1'b1, 1'b0, 7, 7, 0, 2);
      k = 0;
      while (ph != P_IDLE && k < 50) begin
         k++;
         cyc_mode(1'b0, 1'b0, 7, 7, 0, k);
      end
      cyc_mode(1'b0, 1'b0, 0, 0, 0, 0);

      // abort and start together in idle
      cyc_mode(1'b1, 1'b1, 4, 4, 0, 0);
      repeat (2) cyc_mode(1'b0, 1'b0, 0, 0, 0, 0);

      // reset mid-pass
      cyc_mode(1'b1, 1'b0, 5, 5, 0, 0);
      repeat (4) cyc_mode(1'b0, 1'b0, 5, 5, 0, 1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("midpass_reset_outputs", 32'(dut_obs()), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply(1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
      repeat (4) cyc_mode(1'b0, 1'b0, 0, 0, 0, 0);

      for (int p = 0; p < 30; p++)
         drive_pass("random", $urandom_range(0, 6), $urandom_range(0, 6), 3);

      @(posedge clk);
      #1;
      started = 1'b0;
      check("scoreboard_drained", 32'(sq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule

// File: doc/buf_sched.md
BUF_SCHED -- requirements
Module: buf_sched

Interface
REQ-001 Parameter CNT_W, default 8, width of beat counters and configuration inputs.
REQ-002 Parameter N_REQ, fixed at 2, number of write requesters sharing the buffer write port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  pass-start pulse; sampled only in IDLE.
REQ-006 abort  input  1  terminates any pass; returns to IDLE without done.
REQ-007 cfg_writes  input  CNT_W  write beats per pass, latched on accepted start.
REQ-008 cfg_reads  input  CNT_W  read beats per pass, latched on accepted start.
REQ-009 req  input  2  write requests; bit i = requester i has a W_PARAM-word beat ready.
REQ-010 able_write  input  1  buffer status: room for one write beat.
REQ-011 able_read  input  1  buffer status: one read beat available.
REQ-012 cons_ready  input  1  consumer accepts a read beat this cycle.
REQ-013 rst_buf  output  1  buffer clear pulse.
REQ-014 write_en  output  1  buffer write strobe.
REQ-015 gnt  output  2  one-hot write grant; drives the buffer input mux.
REQ-016 read_en  output  1  buffer read strobe.
REQ-017 busy  output  1  high in CLEAR and RUN.
REQ-018 done  output  1  one-cycle pass-complete pulse.
REQ-019 wr_cnt, rd_cnt  output  CNT_W each  beats issued in current pass.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, RUN, DONE; transitions IDLE->CLEAR on start, CLEAR->RUN unconditionally after one cycle, RUN->DONE when wr_cnt==cfg_writes and rd_cnt==cfg_reads, DONE->IDLE unconditionally after one cycle.
REQ-021 start in any state other than IDLE SHALL be ignored; cfg inputs SHALL be ignored except on accepted start.
REQ-022 On accepted start, wr_cnt and rd_cnt SHALL clear to 0 and rr pointer SHALL be preserved.
REQ-023 rst_buf SHALL be 1 exactly during CLEAR, 0 otherwise.
REQ-024 In RUN, grant eligibility SHALL require able_write=1 and wr_cnt<cfg_writes; gnt, write_en SHALL be combinational from state, req, able_write and counters (zero-cycle latency).
REQ-025 Arbitration SHALL be round-robin: if both req bits set, grant the requester not granted last; if one set, grant it; pointer updates only on an actual grant.
REQ-026 write_en SHALL equal OR of gnt; gnt SHALL be 0 outside RUN.
REQ-027 read_en SHALL be 1 iff RUN, able_read=1, cons_ready=1, rd_cnt<cfg_reads.
REQ-028 Write and read beats in the same cycle SHALL both be issued and both counters incremented.
REQ-029 Counters SHALL saturate at cfg value; no wrap; cfg value 0 means no beats of that kind.
REQ-030 cfg_writes=0 and cfg_reads=0 SHALL give CLEAR->RUN->DONE with no strobes.
REQ-031 done SHALL be 1 only in DONE; counters SHALL hold final values in DONE and IDLE until next start.
REQ-032 abort SHALL have priority over all transitions: next state IDLE, no done, strobes 0 in the abort cycle, counters hold.
REQ-033 abort and start together in IDLE SHALL leave FSM in IDLE.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, counters 0, latched cfg 0, rr pointer to requester 0 preferred; all outputs 0 during and after reset.
REQ-035 Reset mid-pass SHALL discard the pass; no done pulse follows release.

Structure
REQ-036 FSM state encoding and CNT_W default SHALL live in the shared PE package.
REQ-037 Round-robin arbiter SHALL be one sub-module, rr_arb2 (req, able, gnt, pointer update).
REQ-038 No datapath storage; buffer data and mux stay outside this block.

Verification
REQ-039 start, cfg_writes=4, cfg_reads=4, req=01 always, able_write=able_read=cons_ready=1 -> rst_buf one cycle, 4 write_en with gnt=01, 4 read_en, done one cycle after final beats, busy low after.
REQ-040 req=11 held, cfg_writes=6 -> gnt sequence 01,10,01,10,01,10.
REQ-041 able_write toggling 1,0,1,0, cfg_writes=2 -> write_en only in able cycles; wr_cnt stops at 2, no further write_en.
REQ-042 cfg_writes=cfg_reads=0 -> done exactly 2 cycles after CLEAR entry, no strobes.
REQ-043 abort asserted after 2 of 5 writes -> IDLE next cycle, wr_cnt=2 held, no done; rst=0 mid-pass -> all outputs 0 immediately.
REQ-044 start pulsed in RUN -> ignored, pass completes with original cfg values.
